// File: rtl/bpsk_pkg.sv
// Shared types and constants for the BPSK burst scheduler and its helpers.
package bpsk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_PREAMBLE,
    ST_PAYLOAD,
    ST_GUARD
  } state_t;

  localparam int   DEFAULT_SAMPLES_PER_BIT = 16;
  localparam logic PREAMBLE_FIRST_BIT      = 1'b1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pb_sync_edge.sv
// Two-flop synchronizer for an asynchronous button plus a registered rising-edge pulse.
module pb_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_pulse
);

  logic r_meta;
  logic r_sync;
  logic r_sync_d;
  logic r_pulse;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_sync_d <= 1'b0;
      r_pulse  <= 1'b0;
    end else begin
      r_meta   <= i_async;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
      r_pulse  <= r_sync & ~r_sync_d;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/bpsk_burst_scheduler.sv
// Frames the BPSK transmit path into counted bursts: sine prime, preamble, payload, guard.
module bpsk_burst_scheduler
  import bpsk_pkg::*;
#(
  parameter int SAMPLES_PER_BIT = DEFAULT_SAMPLES_PER_BIT,
  parameter int PREAMBLE_BITS   = 8,
  parameter int PAYLOAD_BITS    = 32,
  parameter int GUARD_BITS      = 4,
  parameter int PRIME_TIMEOUT   = 255,
  parameter int REPEAT          = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic PB,
  input  logic sine_rdy,
  input  logic data_valid,
  input  logic data_bit,
  output logic data_ready,
  output logic sine_rst,
  output logic sine_clk_en,
  output logic mod_en,
  output logic mod_bit,
  output logic busy,
  output logic underrun,
  output logic fault
);

  localparam int SC_W = $clog2(SAMPLES_PER_BIT + 1);
  localparam int BC_W = $clog2(max3(PREAMBLE_BITS, PAYLOAD_BITS, GUARD_BITS) + 1);
  localparam int WC_W = $clog2(PRIME_TIMEOUT + 1);

  localparam logic [SC_W-1:0] SAMPLE_LAST = SC_W'(SAMPLES_PER_BIT - 1);
  localparam logic [BC_W-1:0] PRE_LAST    = BC_W'(PREAMBLE_BITS - 1);
  localparam logic [BC_W-1:0] PAY_LAST    = BC_W'(PAYLOAD_BITS - 1);
  localparam logic [BC_W-1:0] GUARD_LAST  = BC_W'(GUARD_BITS - 1);
  localparam logic [WC_W-1:0] WAIT_LAST   = WC_W'(PRIME_TIMEOUT - 1);

  state_t            r_state,      w_state_nxt;
  logic [SC_W-1:0]   r_sample_cnt, w_sample_nxt;
  logic [BC_W-1:0]   r_bit_cnt,    w_bit_nxt;
  logic [WC_W-1:0]   r_wait_cnt,   w_wait_nxt;
  logic              r_stop,       w_stop_nxt;
  logic              r_underrun,   w_underrun_nxt;
  logic              r_fault,      w_fault_nxt;
  logic              r_mod_bit,    w_mod_bit_nxt;
  logic              r_data_ready, w_data_ready_nxt;
  logic              r_sine_rst, r_sine_clk_en, r_mod_en, r_busy;
  logic              w_pb_evt, w_boundary, w_handshake;

  pb_sync_edge u_pb_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (PB),
    .o_pulse (w_pb_evt)
  );

  assign w_boundary  = (r_sample_cnt == SAMPLE_LAST);
  assign w_handshake = r_data_ready & data_valid;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_sample_nxt   = r_sample_cnt;
    w_bit_nxt      = r_bit_cnt;
    w_wait_nxt     = r_wait_cnt;
    w_stop_nxt     = r_stop;
    w_underrun_nxt = r_underrun;
    w_fault_nxt    = r_fault;
    w_mod_bit_nxt  = r_mod_bit;

    case (r_state)
      ST_IDLE: begin
        if (w_pb_evt) begin
          w_state_nxt    = ST_PRIME;
          w_wait_nxt     = '0;
          w_stop_nxt     = 1'b0;
          w_underrun_nxt = 1'b0;
          w_fault_nxt    = 1'b0;
        end
      end
      ST_PRIME: begin
        if (w_pb_evt) begin
          w_state_nxt = ST_IDLE;
        end else if (sine_rdy) begin
          w_state_nxt  = ST_PREAMBLE;
          w_sample_nxt = '0;
          w_bit_nxt    = '0;
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_state_nxt = ST_IDLE;
          w_fault_nxt = 1'b1;
        end else begin
          w_wait_nxt = r_wait_cnt + 1'b1;
        end
      end
      ST_PREAMBLE, ST_PAYLOAD: begin
        if (w_pb_evt) w_stop_nxt = 1'b1;
        w_sample_nxt = w_boundary ? '0 : r_sample_cnt + 1'b1;
        if (w_boundary) begin
          // An accepted bit is always transmitted, even if a stop arrives on the same cycle.
          if (w_handshake) begin
            w_state_nxt   = ST_PAYLOAD;
            w_bit_nxt     = (r_state == ST_PAYLOAD) ? r_bit_cnt + 1'b1 : '0;
            w_mod_bit_nxt = data_bit;
          end else if (r_data_ready) begin
            w_underrun_nxt = 1'b1;
            w_state_nxt    = ST_GUARD;
            w_bit_nxt      = '0;
          end else if (r_state == ST_PREAMBLE && r_bit_cnt != PRE_LAST && !w_stop_nxt) begin
            w_bit_nxt = r_bit_cnt + 1'b1;
          end else begin
            w_state_nxt = ST_GUARD;
            w_bit_nxt   = '0;
          end
        end
      end
      ST_GUARD: begin
        if (w_pb_evt) w_stop_nxt = 1'b1;
        w_sample_nxt = w_boundary ? '0 : r_sample_cnt + 1'b1;
        if (w_boundary) begin
          if (r_bit_cnt == GUARD_LAST) begin
            w_bit_nxt   = '0;
            w_state_nxt = (REPEAT == 0 || w_stop_nxt) ? ST_IDLE : ST_PREAMBLE;
          end else begin
            w_bit_nxt = r_bit_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_state_nxt == ST_PREAMBLE) w_mod_bit_nxt = PREAMBLE_FIRST_BIT ^ w_bit_nxt[0];
    else if (w_state_nxt != ST_PAYLOAD) w_mod_bit_nxt = 1'b0;

    // Ready is raised one cycle ahead so it lands on the last sample of the symbol before each payload bit.
    w_data_ready_nxt = (w_sample_nxt == SAMPLE_LAST) && !w_stop_nxt &&
                       ((w_state_nxt == ST_PREAMBLE && w_bit_nxt == PRE_LAST) ||
                        (w_state_nxt == ST_PAYLOAD  && w_bit_nxt != PAY_LAST));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_sample_cnt  <= '0;
      r_bit_cnt     <= '0;
      r_wait_cnt    <= '0;
      r_stop        <= 1'b0;
      r_underrun    <= 1'b0;
      r_fault       <= 1'b0;
      r_mod_bit     <= 1'b0;
      r_data_ready  <= 1'b0;
      r_sine_rst    <= 1'b1;
      r_sine_clk_en <= 1'b0;
      r_mod_en      <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_sample_cnt  <= w_sample_nxt;
      r_bit_cnt     <= w_bit_nxt;
      r_wait_cnt    <= w_wait_nxt;
      r_stop        <= w_stop_nxt;
      r_underrun    <= w_underrun_nxt;
      r_fault       <= w_fault_nxt;
      r_mod_bit     <= w_mod_bit_nxt;
      r_data_ready  <= w_data_ready_nxt;
      r_sine_rst    <= (w_state_nxt == ST_IDLE);
      r_sine_clk_en <= (w_state_nxt != ST_IDLE);
      r_mod_en      <= (w_state_nxt == ST_PREAMBLE) || (w_state_nxt == ST_PAYLOAD);
      r_busy        <= (w_state_nxt != ST_IDLE);
    end
  end

  assign data_ready  = r_data_ready;
  assign sine_rst    = r_sine_rst;
  assign sine_clk_en = r_sine_clk_en;
  assign mod_en      = r_mod_en;
  assign mod_bit     = r_mod_bit;
  assign busy        = r_busy;
  assign underrun    = r_underrun;
  assign fault       = r_fault;

endmodule

// File: doc/bpsk_burst_scheduler.md
Name: bpsk_burst_scheduler

Overview:
Sequences the BPSK transmit datapath (sine generator plus modulator) into framed bursts: sine prime, preamble, payload, guard. Sits between the push-button/data source and the sine generator and modulator. Owns bit timing, the sine generator reset and clock-enable, and the payload-bit handshake. Replaces ad-hoc enable gating with a deterministic, counted burst.

Parameters:
SAMPLES_PER_BIT, 16, clk cycles (sine samples) per symbol; must be ≥2.
PREAMBLE_BITS, 8, alternating 1/0 symbols sent before payload, first symbol 1.
PAYLOAD_BITS, 32, symbols taken from the data source per burst.
GUARD_BITS, 4, symbol periods of carrier-off after payload.
PRIME_TIMEOUT, 255, max cycles waiting for sine_rdy before fault.
REPEAT, 0, 1 = restart at PREAMBLE after GUARD until PB stop; 0 = single burst.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
PB  in  1  raw push-button, asynchronous to clk
sine_rdy  in  1  sine generator primed/valid
data_valid  in  1  payload bit available
data_bit  in  1  payload bit value
data_ready  out  1  payload bit consumed this cycle (valid&ready)
sine_rst  out  1  sine generator reset, active-high
sine_clk_en  out  1  sine generator advance enable
mod_en  out  1  modulator output enable
mod_bit  out  1  current symbol (1 = 0°, 0 = 180°)
busy  out  1  not in IDLE
underrun  out  1  sticky: payload bit unavailable at a symbol boundary
fault  out  1  sticky: PRIME timeout

Behaviour:
- All outputs registered. Reset values: sine_rst=1, all others 0; state=IDLE; counters 0.
- PB: 2-flop synchronizer + rising-edge detect → pb_evt (1-cycle pulse, 3-cycle latency from PB rising).
- States: IDLE, PRIME, PREAMBLE, PAYLOAD, GUARD.
- IDLE: sine_rst=1, enables 0. pb_evt → PRIME; clears underrun and fault.
- PRIME: sine_rst=0, sine_clk_en=1, mod_en=0; wait-counter increments. sine_rdy=1 → PREAMBLE, sample_cnt=0, bit_cnt=0. Counter reaching PRIME_TIMEOUT without sine_rdy → fault=1, IDLE.
- sample_cnt: runs 0..SAMPLES_PER_BIT-1 in PREAMBLE/PAYLOAD/GUARD, wraps; the wrap cycle is the symbol boundary and increments bit_cnt.
- PREAMBLE: sine_clk_en=1, mod_en=1, mod_bit = ~bit_cnt[0]. After bit PREAMBLE_BITS-1 boundary → PAYLOAD, bit_cnt=0.
- PAYLOAD: data_ready=1 only on the cycle where sample_cnt==SAMPLES_PER_BIT-1 (the last sample of the previous symbol, including the final preamble symbol). If data_valid that cycle: data_bit is latched into mod_bit, effective at sample 0 of the next symbol. If not valid: underrun=1, go to GUARD at that boundary, mod_en=0. After PAYLOAD_BITS accepted symbols complete → GUARD.
- data_ready never asserts outside this rule. Exactly PAYLOAD_BITS handshakes per clean burst.
- GUARD: mod_en=0, sine_clk_en=1, mod_bit=0, for GUARD_BITS symbols. Then IDLE if REPEAT=0 or a stop is latched; else PREAMBLE.
- pb_evt while busy: in PRIME → IDLE immediately. In PREAMBLE/PAYLOAD → latch stop, go to GUARD at the next symbol boundary; no further data_ready. In GUARD → latch stop only.
- Simultaneous sine_rdy and pb_evt in PRIME: pb_evt wins (→ IDLE).
- sine_rdy deassert after PRIME: ignored (generator free-runs).
- Async rst mid-burst: all outputs go to their reset values immediately; the in-flight bit is dropped.
- Counter widths: $clog2(param+1).

Decomposition:
- Shared package bpsk_pkg: state enum, default SAMPLES_PER_BIT, preamble pattern constant.
- Sub-module pb_sync_edge: synchronizer + rising-edge pulse, reusable for other board buttons.

Test Plan:
- Reset then idle: rst pulse, PB=0 for 100 cycles → sine_rst=1, mod_en=0, data_ready never 1, busy=0.
- Clean burst (SPB=4, PRE=8, PAY=32, GUARD=4, data_valid=1 always): PB pulse, sine_rdy 5 cycles after PRIME entry → mod_bit 1,0,1,0… for 32 cycles; then exactly 32 data_ready pulses each 4 cycles apart; mod_en low for 16 cycles; then IDLE.
- Underrun: data_valid drops before payload bit 10 → underrun=1, mod_en=0 at that boundary, GUARD, IDLE; only 10 handshakes counted.
- Prime timeout: sine_rdy held 0 → fault=1 after 255 PRIME cycles, state IDLE, sine_rst=1.
- Abort: PB pulse during payload bit 5 (REPEAT=1) → no data_ready after the current symbol; GUARD then IDLE, no restart.
- Async reset mid-PAYLOAD: rst asserted between clk edges → outputs at reset values before the next edge; a new PB starts a fresh burst from PRIME.
